// File: rtl/regs_writeback.sv
// rtl/regs_writeback.sv - writeback stage: in-order pending-write FIFO feeding the register file
// Merges mem/ALU results and SP push/pop pairs; keeps a 32-bit SP shadow.
module regs_writeback #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] SP_STEP  = 32'd1,
  parameter logic [31:0] SP_RESET = 32'h0001_0000
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [3:0]               mem_dst,
  input  logic [15:0]              mem_val,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [3:0]               alu_dst,
  input  logic [15:0]              alu_val,
  input  logic                     sp_op_valid,
  output logic                     sp_op_ready,
  input  logic                     sp_op_pop,
  output logic [31:0]              sp_value,
  output logic                     we,
  output logic [3:0]               src_w,
  output logic [15:0]              val,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CAP     = CW'(DEPTH);
  localparam logic [CW-1:0] SP_ROOM = CW'(DEPTH - 2);

  logic [19:0]   fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, enq_cnt, pop_cnt;
  logic          mem_acc, alu_acc, sp_acc, w_acc, w_en;
  logic [3:0]    w_dst;
  logic [15:0]   w_val;
  logic [31:0]   sp_new;

  // Readiness looks only at registered occupancy; a same-cycle drain earns no credit.
  assign mem_ready   = cpu_rst_n && (count < CAP);
  assign alu_ready   = cpu_rst_n && (count < CAP) && !mem_valid;
  assign sp_op_ready = cpu_rst_n && (count <= SP_ROOM) && !mem_valid && !alu_valid;

  assign mem_acc = mem_valid && mem_ready;
  assign alu_acc = alu_valid && alu_ready;
  assign sp_acc  = sp_op_valid && sp_op_ready;
  assign w_acc   = mem_acc || alu_acc;
  assign w_dst   = mem_acc ? mem_dst : alu_dst;
  assign w_val   = mem_acc ? mem_val : alu_val;
  assign w_en    = w_acc && (w_dst != 4'h0);
  assign sp_new  = sp_op_pop ? (sp_value + SP_STEP) : (sp_value - SP_STEP);

  assign wr_ptr_nxt = wr_ptr + 1'b1;
  assign enq_cnt    = sp_acc ? CW'(2) : (w_en ? CW'(1) : '0);
  assign pop_cnt    = we ? CW'(1) : '0;

  // The register file decodes src_w even when idle, so gate index and data with we.
  assign we      = (count != '0);
  assign src_w   = we ? fifo_q[rd_ptr][19:16] : 4'h0;
  assign val     = we ? fifo_q[rd_ptr][15:0]  : 16'h0;
  assign pending = count;

  always_ff @(posedge cpu_clk) begin
    if (sp_acc) begin
      fifo_q[wr_ptr]     <= {4'hE, sp_new[15:0]};
      fifo_q[wr_ptr_nxt] <= {4'hF, sp_new[31:16]};
    end else if (w_en) begin
      fifo_q[wr_ptr] <= {w_dst, w_val};
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      sp_value <= SP_RESET;
    end else begin
      count <= count + enq_cnt - pop_cnt;
      if (we)
        rd_ptr <= rd_ptr + 1'b1;
      if (sp_acc)
        wr_ptr <= wr_ptr_nxt + 1'b1;
      else if (w_en)
        wr_ptr <= wr_ptr_nxt;
      if (sp_acc)
        sp_value <= sp_new;
      else if (w_acc && w_dst == 4'hE)
        sp_value[15:0] <= w_val;
      else if (w_acc && w_dst == 4'hF)
        sp_value[31:16] <= w_val;
    end
  end
endmodule
